// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS fetch path: redirect commands, fetch FSM states
// and reset/nop constants.
package mips_pkg;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fstate_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

endpackage

// File: rtl/fetch_npc_calc.sv
// Redirect target for the instruction resolved in D; purely combinational.
module npc_calc
  import mips_pkg::*;
(
  input  logic [1:0]  npc_sel,
  input  logic [31:0] PC4_D,
  input  logic [15:0] imm16_D,
  input  logic [25:0] index26_D,
  input  logic [31:0] jr_target_D,
  output logic [31:0] target_o,
  output logic        redir_o
);

  always_comb begin
    target_o = PC4_D;
    case (npc_sel)
      NPC_BR:  target_o = PC4_D + {{14{imm16_D[15]}}, imm16_D, 2'b00};
      NPC_J:   target_o = {PC4_D[31:28], index26_D, 2'b00};
      NPC_JR:  target_o = jr_target_D;
      default: target_o = PC4_D;
    endcase
    redir_o = (npc_sel != NPC_SEQ);
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS F stage: owns the PC, talks to a variable-latency imem, and feeds F/D
// while honouring stalls and a one-instruction delay slot.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] PC4_D,
  input  logic [15:0] imm16_D,
  input  logic [25:0] index26_D,
  input  logic [31:0] jr_target_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PC_F_D,
  output logic [31:0] PC4_F_D,
  output logic [31:0] Instr_F_D,
  output logic        F_D_RegEn
);

  fstate_e     state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic [31:0] target;
  logic        redir, avail, take;
  logic [31:0] next_pc;

  npc_calc u_npc (
    .npc_sel     (npc_sel),
    .PC4_D       (PC4_D),
    .imm16_D     (imm16_D),
    .index26_D   (index26_D),
    .jr_target_D (jr_target_D),
    .target_o    (target),
    .redir_o     (redir)
  );

  always_comb begin
    imem_req  = (state_q == FETCH) & ~reset;
    imem_addr = pc_q;
    PC_F_D    = pc_q;
    PC4_F_D   = pc_q + 32'd4;
    F_D_RegEn = ~stall;
    avail     = (state_q == HOLD) | ((state_q == FETCH) & imem_ready);
    take      = avail & ~stall;

    Instr_F_D = NOP_INSTR;
    if (!reset) begin
      if (state_q == HOLD)  Instr_F_D = hold_instr_q;
      else if (imem_ready)  Instr_F_D = imem_rdata;
    end

    // A redirect arriving this cycle overrides one left pending from a stall.
    if (redir)             next_pc = target;
    else if (pend_valid_q) next_pc = pend_pc_q;
    else                   next_pc = pc_q + 32'd4;

    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;

    if (take) begin
      pc_d         = next_pc;
      state_d      = FETCH;
      pend_valid_d = 1'b0;
    end else begin
      if (redir) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = target;
      end
      // Capture returned data so the request can drop without a refetch.
      if ((state_q == FETCH) && imem_ready && stall) begin
        hold_instr_d = imem_rdata;
        state_d      = HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      state_q      <= FETCH;
      hold_instr_q <= NOP_INSTR;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      state_q      <= state_d;
      hold_instr_q <= hold_instr_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage: per-cycle input vectors with expected
// F/D outputs, routed through a scoreboard queue.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, imem_ready;
  logic [1:0]  npc_sel;
  logic [31:0] PC4_D, jr_target_D;
  logic [15:0] imm16_D;
  logic [25:0] index26_D;
  logic        imem_req, F_D_RegEn;
  logic [31:0] imem_addr, imem_rdata, PC_F_D, PC4_F_D, Instr_F_D;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Garbage while not ready so an unmasked bubble is visible.
  assign imem_rdata = imem_ready ? rom(imem_addr) : 32'hDEAD_BEEF;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel),
    .PC4_D(PC4_D), .imm16_D(imm16_D), .index26_D(index26_D),
    .jr_target_D(jr_target_D), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .PC_F_D(PC_F_D),
    .PC4_F_D(PC4_F_D), .Instr_F_D(Instr_F_D), .F_D_RegEn(F_D_RegEn)
  );

  typedef struct {
    logic        rst, stl, rdy;
    logic [1:0]  sel;
    logic [31:0] pc4d;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] jr;
    logic [31:0] exp_pc;
    logic        exp_bub;
    logic        exp_req;
  } vec_t;

  typedef struct {
    logic [31:0] pc, pc4, instr;
    logic        regen, req;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic stl, logic rdy, logic [1:0] sel,
                              logic [31:0] pc4d, logic [15:0] imm, logic [25:0] idx,
                              logic [31:0] jr, logic [31:0] exp_pc, logic exp_bub,
                              logic exp_req);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdy = rdy; v.sel = sel; v.pc4d = pc4d;
    v.imm = imm; v.idx = idx; v.jr = jr; v.exp_pc = exp_pc;
    v.exp_bub = exp_bub; v.exp_req = exp_req;
    return v;
  endfunction

  task automatic chk(input string name, input int n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  // Drive one cycle, push expectation, compare mid-cycle, advance past posedge.
  task automatic apply(input int n, input vec_t v);
    exp_t e, g;
    reset = v.rst; stall = v.stl; imem_ready = v.rdy; npc_sel = v.sel;
    PC4_D = v.pc4d; imm16_D = v.imm; index26_D = v.idx; jr_target_D = v.jr;
    e.pc    = v.exp_pc;
    e.pc4   = v.exp_pc + 32'd4;
    e.instr = v.exp_bub ? 32'h0 : rom(v.exp_pc);
    e.regen = ~v.stl;
    e.req   = v.exp_req;
    sb.push_back(e);
    #4;
    g = sb.pop_front();
    chk("PC_F_D", n, PC_F_D, g.pc);
    chk("PC4_F_D", n, PC4_F_D, g.pc4);
    chk("Instr_F_D", n, Instr_F_D, g.instr);
    chk("imem_addr", n, imem_addr, g.pc);
    chk("F_D_RegEn", n, {31'b0, F_D_RegEn}, {31'b0, g.regen});
    chk("imem_req", n, {31'b0, imem_req}, {31'b0, g.req});
    @(posedge clk); #1;
  endtask

  initial begin
    // rst stl rdy sel pc4d imm idx jr | exp_pc bub req
    tbl.push_back(mk(1,0,1,2'b00,0,0,0,0,                  32'h3000,1,0)); // reset
    tbl.push_back(mk(0,0,1,2'b00,0,0,0,0,                  32'h3000,0,1));
    tbl.push_back(mk(0,0,1,2'b01,32'h3008,16'hFFFF,0,0,    32'h3004,0,1)); // beq -4
    tbl.push_back(mk(0,0,1,2'b01,32'h3008,16'h0004,0,0,    32'h3004,0,1)); // beq +16
    tbl.push_back(mk(0,0,0,2'b10,32'h301C,0,26'h100,0,     32'h3018,1,1)); // j while not ready
    tbl.push_back(mk(0,0,0,2'b00,0,0,0,0,                  32'h3018,1,1));
    tbl.push_back(mk(0,0,0,2'b00,0,0,0,0,                  32'h3018,1,1));
    tbl.push_back(mk(0,0,1,2'b00,0,0,0,0,                  32'h3018,0,1)); // delay slot
    tbl.push_back(mk(0,0,1,2'b00,0,0,0,0,                  32'h0400,0,1));
    tbl.push_back(mk(0,1,1,2'b00,0,0,0,0,                  32'h0404,0,1)); // stall -> HOLD
    tbl.push_back(mk(0,1,1,2'b00,0,0,0,0,                  32'h0404,0,0));
    tbl.push_back(mk(0,0,1,2'b00,0,0,0,0,                  32'h0404,0,0)); // release
    tbl.push_back(mk(0,0,1,2'b00,0,0,0,0,                  32'h0408,0,1));
    tbl.push_back(mk(0,0,0,2'b10,32'h0,0,26'h100,0,        32'h040C,1,1)); // pend j 0x400
    tbl.push_back(mk(0,0,1,2'b11,0,0,0,32'h4000,           32'h040C,0,1)); // jr wins
    tbl.push_back(mk(0,0,1,2'b00,0,0,0,0,                  32'h4000,0,1));
    tbl.push_back(mk(0,0,0,2'b10,32'h0,0,26'h100,0,        32'h4004,1,1)); // pend set
    tbl.push_back(mk(1,0,0,2'b00,0,0,0,0,                  32'h4004,1,0)); // reset mid-req
    tbl.push_back(mk(0,0,1,2'b00,0,0,0,0,                  32'h3000,0,1));
    tbl.push_back(mk(0,0,1,2'b00,0,0,0,0,                  32'h3004,0,1)); // pend cleared
    tbl.push_back(mk(0,0,1,2'b11,0,0,0,32'hFFFF_FFFC,      32'h3008,0,1));
    tbl.push_back(mk(0,0,1,2'b00,0,0,0,0,                  32'hFFFF_FFFC,0,1)); // wrap
    tbl.push_back(mk(0,0,1,2'b00,0,0,0,0,                  32'h0000_0000,0,1));
    tbl.push_back(mk(0,1,0,2'b00,0,0,0,0,                  32'h0000_0004,1,1)); // stall+bubble
    tbl.push_back(mk(0,0,1,2'b00,0,0,0,0,                  32'h0000_0004,0,1));

    reset = 1'b1; stall = 1'b0; imem_ready = 1'b1; npc_sel = 2'b00;
    PC4_D = '0; imm16_D = '0; index26_D = '0; jr_target_D = '0;
    @(posedge clk); #1;

    foreach (tbl[i]) apply(i, tbl[i]);

    // Redirect held pending across a HOLD stall, repeated each cycle.
    apply(100, mk(0,1,1,2'b01,32'h0100,16'h0001,0,0, 32'h0000_0008,0,1));
    apply(101, mk(0,1,1,2'b01,32'h0100,16'h0001,0,0, 32'h0000_0008,0,0));
    apply(102, mk(0,0,0,2'b00,0,0,0,0,               32'h0000_0008,0,0));
    apply(103, mk(0,0,1,2'b00,0,0,0,0,               32'h0000_0104,0,1));
    apply(104, mk(0,0,1,2'b00,0,0,0,0,               32'h0000_0108,0,1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
